// File: rtl/mux2_1_arbiter_if.sv
// rtl/mux2_1_arbiter_if.sv - requester/output handshake bundle for mux2_1_arbiter
interface mux2_1_arbiter_if #(parameter int WIDTH = 12);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, sel, out_valid, out_data
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, sel, out_valid, out_data
  );
endinterface

// File: rtl/mux2_1_arbiter.sv
// rtl/mux2_1_arbiter.sv - round-robin burst-limited arbiter driving a 2:1 mux into a one-word output stage
module mux2_1_arbiter #(
  parameter int WIDTH = 12,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux2_1_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [4:0] BURST_W = 5'(BURST);

  state_t           state;
  logic             last;
  logic [3:0]       cnt;
  logic             sel_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             slot_free;
  logic             cur;
  logic             cur_valid;
  logic             oth_valid;
  logic             accept;
  logic             burst_end;
  logic [WIDTH-1:0] mux_data;

  assign slot_free = !out_valid_q || bus.out_ready;

  assign bus.req0_ready = (state == GRANT0) && slot_free;
  assign bus.req1_ready = (state == GRANT1) && slot_free;
  assign bus.sel        = sel_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;

  assign cur       = (state == GRANT1);
  assign cur_valid = cur ? bus.req1_valid : bus.req0_valid;
  assign oth_valid = cur ? bus.req0_valid : bus.req1_valid;
  assign accept    = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
  assign burst_end = ({1'b0, cnt} + 5'd1) >= BURST_W;

  // sel only changes on grant entry, so the mux output matches the granted requester
  assign mux_data = sel_q ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel_q       <= 1'b0;
      last        <= 1'b1;
      cnt         <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        out_data_q  <= mux_data;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.req0_valid && (!bus.req1_valid || last)) begin
            state <= GRANT0;
            last  <= 1'b0;
            sel_q <= 1'b0;
            cnt   <= 4'd0;
          end else if (bus.req1_valid) begin
            state <= GRANT1;
            last  <= 1'b1;
            sel_q <= 1'b1;
            cnt   <= 4'd0;
          end
        end

        GRANT0, GRANT1: begin
          if (accept) begin
            if (!burst_end) begin
              cnt <= cnt + 4'd1;
            end else begin
              cnt <= 4'd0;
              if (oth_valid) begin
                state <= cur ? GRANT0 : GRANT1;
                last  <= !cur;
                sel_q <= !cur;
              end
            end
          end else if (!cur_valid) begin
            cnt <= 4'd0;
            if (oth_valid) begin
              state <= cur ? GRANT0 : GRANT1;
              last  <= !cur;
              sel_q <= !cur;
            end else begin
              state <= IDLE;
            end
          end
          // stall (valid held, slot busy): cnt and grant hold
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
